// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset control sequencer.
// Consumed by mips_ctrl_class and mips_multicycle_ctrl.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_RTYPE,
    CLS_ADDI,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_JUMP,
    CLS_ILLEGAL
  } instr_class_t;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  function automatic logic is_mem_class(input instr_class_t c);
    return (c == CLS_LW) || (c == CLS_SW);
  endfunction

  function automatic logic uses_imm(input instr_class_t c);
    return (c == CLS_ADDI) || (c == CLS_LW) || (c == CLS_SW);
  endfunction

endpackage

// File: rtl/mips_ctrl_class.sv
// Combinational instruction classifier: opcode/funct -> instruction class, ALU op, legality.
module mips_ctrl_class
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_t cls,
  output logic [3:0]   alu_op,
  output logic         legal
);

  always_comb begin
    cls    = CLS_ILLEGAL;
    alu_op = ALU_ADD;
    legal  = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        cls   = CLS_RTYPE;
        legal = 1'b1;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: begin
            cls   = CLS_ILLEGAL;
            legal = 1'b0;
          end
        endcase
      end
      OPC_ADDI: begin
        cls   = CLS_ADDI;
        legal = 1'b1;
      end
      OPC_LW: begin
        cls   = CLS_LW;
        legal = 1'b1;
      end
      OPC_SW: begin
        cls   = CLS_SW;
        legal = 1'b1;
      end
      OPC_BEQ: begin
        cls    = CLS_BEQ;
        alu_op = ALU_SUB;
        legal  = 1'b1;
      end
      OPC_J: begin
        cls   = CLS_JUMP;
        legal = 1'b1;
      end
      default: begin
        cls   = CLS_ILLEGAL;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle sequencer for the MIPS-subset core: one datapath phase per state, memory wait states, halt on illegal op.
// Optional feature macro PERF_COUNT_EN adds cyc_cnt/instr_cnt performance counters.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
`ifdef PERF_COUNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_imm,
  output logic [3:0] alu_op,
  output logic       busy,
  output logic       halted
`ifdef PERF_COUNT_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  localparam int WAIT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_WAIT_MAX);

  state_t             state;
  state_t             next_state;
  instr_class_t       cls_dec;
  instr_class_t       cls_q;
  logic [3:0]         alu_dec;
  logic [3:0]         alu_q;
  logic               legal_dec;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               mem_phase;
  logic               mem_timeout;
  logic               bound;

  mips_ctrl_class u_class (
    .opcode (opcode),
    .funct  (funct),
    .cls    (cls_dec),
    .alu_op (alu_dec),
    .legal  (legal_dec)
  );

  assign mem_phase   = (state == FETCH) || (state == MEM);
  assign mem_timeout = mem_phase && !mem_ready && (wait_cnt == WAIT_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The IR is only valid from DECODE on, so the class is captured there and reused by later phases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls_q    <= CLS_ILLEGAL;
      alu_q    <= ALU_ADD;
      wait_cnt <= '0;
    end else begin
      if (state == DECODE) begin
        cls_q <= cls_dec;
        alu_q <= alu_dec;
      end
      if (mem_phase && !mem_ready) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  always_comb begin
    next_state = state;
    bound      = 1'b0;
    case (state)
      IDLE: begin
        if (run) next_state = FETCH;
      end
      FETCH: begin
        if (mem_ready)        next_state = DECODE;
        else if (mem_timeout) next_state = HALT;
      end
      DECODE: begin
        if (!legal_dec)                 next_state = HALT;
        else if (cls_dec == CLS_JUMP)   bound      = 1'b1;
        else                            next_state = EXEC;
      end
      EXEC: begin
        if (cls_q == CLS_BEQ)       bound      = 1'b1;
        else if (is_mem_class(cls_q)) next_state = MEM;
        else                        next_state = WB;
      end
      MEM: begin
        if (mem_ready) begin
          if (cls_q == CLS_SW) bound      = 1'b1;
          else                 next_state = WB;
        end else if (mem_timeout) begin
          next_state = HALT;
        end
      end
      WB: begin
        bound = 1'b1;
      end
      HALT: begin
        next_state = HALT;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    // The instruction boundary costs no cycle: run is sampled here to pick the next fetch or idle.
    if (bound) next_state = run ? FETCH : IDLE;
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PC_SRC_SEQ;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_imm = 1'b0;
    alu_op      = ALU_ADD;
    busy        = (state != IDLE) && (state != HALT);
    halted      = (state == HALT);
    case (state)
      FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      DECODE: begin
        if (legal_dec && (cls_dec == CLS_JUMP)) begin
          pc_write = 1'b1;
          pc_src   = PC_SRC_JUMP;
        end
      end
      EXEC: begin
        alu_op      = alu_q;
        alu_src_imm = uses_imm(cls_q);
        if (cls_q == CLS_BEQ) begin
          pc_write = zero;
          pc_src   = PC_SRC_BRANCH;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (cls_q == CLS_SW);
      end
      WB: begin
        reg_write  = 1'b1;
        reg_dst    = (cls_q == CLS_RTYPE);
        mem_to_reg = (cls_q == CLS_LW);
      end
      default: begin
      end
    endcase
  end

`ifdef PERF_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt   <= '0;
      instr_cnt <= '0;
    end else begin
      if (busy)  cyc_cnt   <= cyc_cnt + CNT_W'(1);
      if (bound) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
